// File: rtl/stud_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : stud_sample_capture
// Purpose  : Captures a sample word that arrives through a per-bit FF
//            synchronizer together with a request toggle. Because each bit
//            of the word can settle on a different cycle, the block waits for
//            STABLE_CYC identical consecutive samples after every toggle edge.
//            The settled word is then pushed into a small FIFO. The FIFO hands
//            words to the DAC datapath through a valid/ready interface.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i       in   1               system clock, rising edge
//   rst_n_i     in   1               asynchronous active-low reset
//   data_i      in   WIDTH           synchronized sample word
//   toggle_i    in   1               synchronized request toggle
//   sample_o    out  WIDTH           FIFO head word
//   valid_o     out  1               FIFO not empty
//   ready_i     in   1               consumer accepts head when valid_o
//   overflow_o  out  1               sticky lost-sample flag
//   clr_ovf_i   in   1               synchronous clear of overflow_o
//   fill_o      out  $clog2(DEPTH)+1 number of occupied FIFO entries
// ============================================================================
module stud_sample_capture #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 4,
  parameter int STABLE_CYC = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     toggle_i,
  output logic [WIDTH-1:0]         sample_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     overflow_o,
  input  logic                     clr_ovf_i,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int          PTR_W    = $clog2(DEPTH);
  localparam int          FILL_W   = PTR_W + 1;
  localparam logic [3:0]  CNT_LAST = 4'(STABLE_CYC - 1);
  localparam bit          SINGLE   = (STABLE_CYC == 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                toggle_q;
  logic [WIDTH-1:0]    shadow_q, shadow_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [FILL_W-1:0]   fill_q;
  logic                ovf_q;

  logic                req_edge;
  logic                push;
  logic                discard;
  logic [WIDTH-1:0]    push_word;
  logic                full;
  logic                pop;
  logic                wr_en;
  logic                drop;

  // toggle_q resets to 0, so a high toggle_i on the first clock after reset
  // is seen as a request.
  assign req_edge = toggle_i ^ toggle_q;

  // --------------------------------------------------------------------------
  // Settle FSM: next state, shadow word, stability counter, push request
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_word = shadow_q;
    discard   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_edge) begin
          if (SINGLE) begin
            push      = 1'b1;
            push_word = data_i;
          end else begin
            shadow_d = data_i;
            cnt_d    = 4'd1;
            state_d  = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (req_edge) begin
          // A new request before the old one settled: the old one is lost.
          discard  = 1'b1;
          shadow_d = data_i;
          cnt_d    = 4'd1;
        end else if (data_i != shadow_q) begin
          // Bits still moving: restart the stability window on the new value.
          shadow_d = data_i;
          cnt_d    = 4'd1;
        end else if (cnt_q == CNT_LAST) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO control. A pop frees a slot in the same cycle, so a push into a full
  // FIFO succeeds when a pop happens alongside it.
  // --------------------------------------------------------------------------
  assign full  = (fill_q == FILL_W'(DEPTH));
  assign pop   = (fill_q != '0) && ready_i;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      toggle_q <= 1'b0;
      shadow_q <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      toggle_q <= toggle_i;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
      // Setting wins over a simultaneous clear.
      if (discard || drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign sample_o   = mem_q[rd_ptr_q];
  assign valid_o    = (fill_q != '0);
  assign fill_o     = fill_q;
  assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stud_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_stud_sample_capture
// Purpose  : Self-checking bench for stud_sample_capture. It runs directed
//            scenarios and then a randomized phase. A queue-based reference
//            model predicts fill, valid, head word and overflow every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_stud_sample_capture;

  localparam int WIDTH      = 16;
  localparam int DEPTH      = 4;
  localparam int STABLE_CYC = 2;
  localparam int FW         = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  data;
  logic              toggle;
  logic              ready;
  logic              clr;
  logic [WIDTH-1:0]  sample;
  logic              valid;
  logic              ovf;
  logic [FW-1:0]     fill;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0]  q[$];
  logic              m_ovf;
  logic              m_pend;
  logic              m_prev_tog;
  logic [WIDTH-1:0]  m_cand;
  int                m_run;

  always #5 clk = ~clk;

  stud_sample_capture #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .STABLE_CYC(STABLE_CYC)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .toggle_i(toggle),
    .sample_o(sample), .valid_o(valid), .ready_i(ready),
    .overflow_o(ovf), .clr_ovf_i(clr), .fill_o(fill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf      = 1'b0;
    m_pend     = 1'b0;
    m_prev_tog = 1'b0;
    m_cand     = '0;
    m_run      = 0;
  endtask

  // One clock of the behavioural rules: a request needs STABLE_CYC equal
  // samples; a new request while one is pending loses the pending one; a
  // push into a full queue is lost unless the head leaves in the same cycle.
  task automatic model_step();
    logic             req;
    logic             do_push;
    logic             do_pop;
    logic             set_ovf;
    logic [WIDTH-1:0] w;
    req        = (toggle != m_prev_tog);
    m_prev_tog = toggle;
    do_push    = 1'b0;
    set_ovf    = 1'b0;
    w          = '0;
    if (req) begin
      if (m_pend) set_ovf = 1'b1;
      if (STABLE_CYC == 1) begin
        do_push = 1'b1;
        w       = data;
        m_pend  = 1'b0;
      end else begin
        m_pend = 1'b1;
        m_cand = data;
        m_run  = 1;
      end
    end else if (m_pend) begin
      if (data == m_cand) begin
        m_run++;
        if (m_run >= STABLE_CYC) begin
          do_push = 1'b1;
          w       = m_cand;
          m_pend  = 1'b0;
        end
      end else begin
        m_cand = data;
        m_run  = 1;
      end
    end
    do_pop = (q.size() > 0) && ready;
    if (do_push && q.size() == DEPTH && !do_pop) begin
      set_ovf = 1'b1;
      do_push = 1'b0;
    end
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(w);
    if (set_ovf) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".fill"},  32'(fill),  32'(q.size()));
    chk({tag, ".valid"}, 32'(valid), 32'(q.size() != 0));
    chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    if (q.size() != 0) chk({tag, ".sample"}, 32'(sample), 32'(q[0]));
  endtask

  // Advance one clock, update the model, then sample the DUT 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  // Flip the toggle with a word, then hold the word for one more clock.
  task automatic send(input logic [WIDTH-1:0] w, input string tag);
    data   = w;
    toggle = ~toggle;
    cycle(tag);
    cycle(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] exp_list [4];
    rst_n  = 1'b0;
    data   = '0;
    toggle = 1'b0;
    ready  = 1'b0;
    clr    = 1'b0;
    model_reset();

    // ---- Reset state
    #12;
    chk("rst.sample", 32'(sample), 32'h0);
    chk("rst.valid",  32'(valid),  32'h0);
    chk("rst.fill",   32'(fill),   32'h0);
    chk("rst.ovf",    32'(ovf),    32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("idle");

    // ---- Stable word, push two cycles after the toggle change
    data   = 16'h1234;
    toggle = 1'b1;
    cycle("t1.k");
    chk("t1.valid_k", 32'(valid), 32'h0);
    cycle("t1.k1");
    chk("t1.valid",  32'(valid),  32'h1);
    chk("t1.sample", 32'(sample), 32'h1234);
    chk("t1.fill",   32'(fill),   32'h1);
    ready = 1'b1; cycle("t1.drain"); ready = 1'b0;

    // ---- Unstable first cycle: only the settled word is pushed, one cycle later
    data   = 16'h00FF;
    toggle = ~toggle;
    cycle("t2.a");
    data = 16'h0F0F;
    cycle("t2.b");
    chk("t2.valid_b", 32'(valid), 32'h0);
    cycle("t2.c");
    chk("t2.sample", 32'(sample), 32'h0F0F);
    chk("t2.fill",   32'(fill),   32'h1);
    ready = 1'b1; cycle("t2.drain"); ready = 1'b0;

    // ---- Five words into a 4-deep FIFO: fifth lost, order preserved
    for (int i = 1; i <= 5; i++) send(WIDTH'(i), "t3.fill");
    chk("t3.fill", 32'(fill), 32'h4);
    chk("t3.ovf",  32'(ovf),  32'h1);
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t3.order", 32'(sample), 32'(i));
      cycle("t3.drain");
    end
    ready = 1'b0;
    clr = 1'b1; cycle("t3.clr"); clr = 1'b0;
    chk("t3.ovf_clr", 32'(ovf), 32'h0);

    // ---- Push and pop together while full
    send(16'hA001, "t4"); send(16'hA002, "t4");
    send(16'hA003, "t4"); send(16'hA004, "t4");
    data   = 16'hA005;
    toggle = ~toggle;
    cycle("t4.k");
    ready = 1'b1;
    cycle("t4.k1");
    ready = 1'b0;
    chk("t4.fill", 32'(fill), 32'h4);
    chk("t4.ovf",  32'(ovf),  32'h0);
    exp_list[0] = 16'hA002; exp_list[1] = 16'hA003;
    exp_list[2] = 16'hA004; exp_list[3] = 16'hA005;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4.order", 32'(sample), 32'(exp_list[i]));
      cycle("t4.drain");
    end
    ready = 1'b0;

    // ---- Second toggle inside the settle window
    data = 16'hAAAA; toggle = ~toggle; cycle("t5.a");
    data = 16'h5555; toggle = ~toggle; cycle("t5.b");
    chk("t5.ovf", 32'(ovf), 32'h1);
    cycle("t5.c");
    chk("t5.fill",   32'(fill),   32'h1);
    chk("t5.sample", 32'(sample), 32'h5555);
    clr = 1'b1; cycle("t5.clr"); clr = 1'b0;
    chk("t5.ovf_clr", 32'(ovf), 32'h0);
    ready = 1'b1; cycle("t5.drain"); ready = 1'b0;

    // ---- Asynchronous reset mid-settle with two words stored
    send(16'hBEEF, "t6"); send(16'hCAFE, "t6");
    data = 16'h1111; toggle = ~toggle; cycle("t6.a");
    data = 16'h2222; toggle = ~toggle; cycle("t6.b");
    chk("t6.fill_pre", 32'(fill), 32'h2);
    chk("t6.ovf_pre",  32'(ovf),  32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6.valid", 32'(valid), 32'h0);
    chk("t6.fill",  32'(fill),  32'h0);
    chk("t6.ovf",   32'(ovf),   32'h0);
    toggle = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cycle("t6.post");
    chk("t6.nopush", 32'(fill), 32'h0);

    // ---- Toggle already high on the first clock after reset
    rst_n = 1'b0;
    toggle = 1'b1;
    data = 16'h7777;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("t7.k");
    cycle("t7.k1");
    chk("t7.sample", 32'(sample), 32'h7777);

    // ---- Randomized phase against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) toggle = ~toggle;
      if ($urandom_range(0, 2) == 0) data = WIDTH'($urandom_range(0, 3));
      ready = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
